// File: rtl/keccak_permute_engine.sv
// Keccak pi / rho+pi permutation engine, Z_STEP z-slices per cycle, start/busy/done handshake.
// Optional inverse permutation enabled by defining PERMUTE_INVERSE_EN.
module keccak_permute_engine #(
  parameter int unsigned LANE_W = 64,
  parameter int unsigned Z_STEP = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  input  logic                  inv,
  input  logic [25*LANE_W-1:0]  data_in,
  output logic                  busy,
  output logic                  done,
  output logic [25*LANE_W-1:0]  data_out
);

  localparam int unsigned NBITS   = 25 * LANE_W;
  localparam int unsigned NSTEP   = LANE_W / Z_STEP;
  localparam int unsigned ZC_W    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam logic [ZC_W-1:0] ZC_LAST = ZC_W'(NSTEP - 1);

  // Keccak rotation offsets, indexed by x*5 + y.
  localparam int unsigned RHO [25] = '{
     0, 36,  3, 41, 18,
     1, 44, 10, 45,  2,
    62,  6, 43, 15, 61,
    28, 55, 25, 21, 56,
    27, 20, 39,  8, 14
  };

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic [NBITS-1:0]  in_reg;
  logic [NBITS-1:0]  out_nxt;
  logic [ZC_W-1:0]   zc;
  logic              mode_r;

  // Each result bit is produced by its source bit; the slice of that source decides the cycle it is written.
  function automatic int unsigned src_fwd(int unsigned d, bit rho);
    int unsigned zd, yd, xd, xs, ys, zs;
    zd = d / 25;
    yd = (d % 25) / 5;
    xd = d % 5;
    xs = (3 * yd + xd) % 5;
    ys = xd;
    zs = rho ? ((zd - RHO[xs*5 + ys]) & (LANE_W - 1)) : zd;
    return zs * 25 + ys * 5 + xs;
  endfunction

`ifdef PERMUTE_INVERSE_EN
  logic inv_r;

  function automatic int unsigned src_inv(int unsigned d, bit rho);
    int unsigned zd, yd, xd, xs, ys, zs;
    zd = d / 25;
    yd = (d % 25) / 5;
    xd = d % 5;
    xs = yd;
    ys = (2 * xd + 3 * yd) % 5;
    zs = rho ? ((zd + RHO[xd*5 + yd]) & (LANE_W - 1)) : zd;
    return zs * 25 + ys * 5 + xs;
  endfunction
`else
  logic unused_inv;
  assign unused_inv = inv;
`endif

  for (genvar d = 0; d < NBITS; d++) begin : g_bit
    localparam int unsigned PI_SRC = src_fwd(d, 1'b0);
    localparam int unsigned RP_SRC = src_fwd(d, 1'b1);
    localparam logic [ZC_W-1:0] PI_ZC = ZC_W'((PI_SRC / 25) / Z_STEP);
    localparam logic [ZC_W-1:0] RP_ZC = ZC_W'((RP_SRC / 25) / Z_STEP);
    logic fwd_bit;

    assign fwd_bit = mode_r ? ((zc == RP_ZC) ? in_reg[RP_SRC] : data_out[d])
                            : ((zc == PI_ZC) ? in_reg[PI_SRC] : data_out[d]);
`ifdef PERMUTE_INVERSE_EN
    localparam int unsigned IP_SRC = src_inv(d, 1'b0);
    localparam int unsigned IR_SRC = src_inv(d, 1'b1);
    localparam logic [ZC_W-1:0] IP_ZC = ZC_W'((IP_SRC / 25) / Z_STEP);
    localparam logic [ZC_W-1:0] IR_ZC = ZC_W'((IR_SRC / 25) / Z_STEP);
    logic inv_bit;

    assign inv_bit = mode_r ? ((zc == IR_ZC) ? in_reg[IR_SRC] : data_out[d])
                            : ((zc == IP_ZC) ? in_reg[IP_SRC] : data_out[d]);
    assign out_nxt[d] = inv_r ? inv_bit : fwd_bit;
`else
    assign out_nxt[d] = fwd_bit;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (zc == ZC_LAST) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_reg   <= '0;
      data_out <= '0;
      zc       <= '0;
      mode_r   <= 1'b0;
`ifdef PERMUTE_INVERSE_EN
      inv_r    <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: if (start) begin
          in_reg   <= data_in;
          mode_r   <= mode;
`ifdef PERMUTE_INVERSE_EN
          inv_r    <= inv;
`endif
          data_out <= '0;
          zc       <= '0;
        end
        RUN: begin
          data_out <= out_nxt;
          zc       <= (zc == ZC_LAST) ? '0 : zc + ZC_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_keccak_permute_engine.sv
// Self-checking bench for keccak_permute_engine: two instances (Z_STEP=1 and 4) against a lane-level Keccak model.
module tb_keccak_permute_engine;

  localparam int unsigned LW = 64;
  localparam int unsigned NB = 25 * LW;
`ifdef PERMUTE_INVERSE_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start1 = 1'b0, start4 = 1'b0;
  logic          mode = 1'b0, inv = 1'b0;
  logic [NB-1:0] data_in = '0;
  logic [NB-1:0] out1, out4;
  logic          busy1, done1, busy4, done4;

  int unsigned errors = 0;
  int unsigned checks = 0;

  int unsigned rc [25] = '{0, 36, 3, 41, 18, 1, 44, 10, 45, 2, 62, 6, 43, 15, 61,
                           28, 55, 25, 21, 56, 27, 20, 39, 8, 14};

  keccak_permute_engine #(.LANE_W(LW), .Z_STEP(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .mode(mode), .inv(inv),
    .data_in(data_in), .busy(busy1), .done(done1), .data_out(out1));

  keccak_permute_engine #(.LANE_W(LW), .Z_STEP(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .mode(mode), .inv(inv),
    .data_in(data_in), .busy(busy4), .done(done4), .data_out(out4));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reports the first differing 64-bit word (word 0 when equal).
  task automatic check_vec(input string tag, input logic [NB-1:0] got, input logic [NB-1:0] exp);
    int w;
    w = 0;
    for (int i = 0; i < 25; i++)
      if (got[i*64 +: 64] !== exp[i*64 +: 64]) begin
        w = i;
        break;
      end
    check($sformatf("%s.w%0d", tag, w), got[w*64 +: 64], exp[w*64 +: 64]);
  endtask

  function automatic logic [NB-1:0] rand_state();
    logic [NB-1:0] r;
    for (int i = 0; i < NB / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [LW-1:0] rotl(input logic [LW-1:0] v, input int unsigned n);
    if (n == 0) return v;
    return (v << n) | (v >> (LW - n));
  endfunction

  // Lane-level model: B[y][2x+3y] = rotl(A[x][y], r[x][y]); inverse undoes it lane by lane.
  function automatic logic [NB-1:0] ref_perm(input logic [NB-1:0] s, input bit rho, input bit iv);
    logic [LW-1:0] a [5][5];
    logic [LW-1:0] b [5][5];
    logic [NB-1:0] r;
    int unsigned dx, dy, sh;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        for (int z = 0; z < LW; z++) a[x][y][z] = s[z*25 + y*5 + x];
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++) begin
        dx = y;
        dy = (2 * x + 3 * y) % 5;
        sh = rho ? rc[x*5 + y] % LW : 0;
        if (!iv) b[dx][dy] = rotl(a[x][y], sh);
        else     b[x][y]   = rotl(a[dx][dy], (LW - sh) % LW);
      end
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        for (int z = 0; z < LW; z++) r[z*25 + y*5 + x] = b[x][y][z];
    return r;
  endfunction

  function automatic logic busy_of(input int sel);
    return (sel != 0) ? busy4 : busy1;
  endfunction
  function automatic logic done_of(input int sel);
    return (sel != 0) ? done4 : done1;
  endfunction
  function automatic logic [NB-1:0] out_of(input int sel);
    return (sel != 0) ? out4 : out1;
  endfunction

  // Entered #1 after the accepting edge; leaves #1 after the edge following DONE.
  task automatic wait_done(input int sel, input string tag, output logic [NB-1:0] res);
    int unsigned cnt, n;
    cnt = 0;
    n = (sel != 0) ? 16 : 64;
    while (busy_of(sel) && cnt < 300) begin
      cnt++;
      @(posedge clk); #1;
    end
    check({tag, ".busy_cycles"}, 64'(cnt), 64'(n));
    check({tag, ".done"}, 64'(done_of(sel)), 64'd1);
    res = out_of(sel);
    @(posedge clk); #1;
    check({tag, ".done_clr"}, 64'(done_of(sel)), 64'd0);
    check_vec({tag, ".hold"}, out_of(sel), res);
  endtask

  task automatic run_op(input int sel, input logic [NB-1:0] din, input bit m, input bit iv,
                        input string tag, output logic [NB-1:0] res);
    @(negedge clk);
    data_in = din;
    mode    = m;
    inv     = iv;
    if (sel != 0) start4 = 1'b1;
    else          start1 = 1'b1;
    @(posedge clk); #1;
    start1  = 1'b0;
    start4  = 1'b0;
    data_in = rand_state();
    mode    = ~m;
    inv     = ~iv;
    check_vec({tag, ".clr"}, out_of(sel), '0);
    wait_done(sel, tag, res);
    check_vec({tag, ".res"}, res, ref_perm(din, m, iv & INV_EN));
  endtask

  initial begin
    logic [NB-1:0] v, e, s, a, b, res, res2;
    int unsigned cnt;

    repeat (3) @(posedge clk);
    #1;
    check("rst.busy1", 64'(busy1), 64'd0);
    check("rst.done1", 64'(done1), 64'd0);
    check_vec("rst.out1", out1, '0);
    check("rst.busy4", 64'(busy4), 64'd0);
    check_vec("rst.out4", out4, '0);
    @(negedge clk) rst = 1'b0;

    v = '0; v[1] = 1'b1; e = '0; e[10] = 1'b1;
    run_op(0, v, 1'b0, 1'b0, "pi_b1", res);
    check_vec("pi_b1.only10", res, e);

    v = '0; v[5] = 1'b1; e = '0; e[916] = 1'b1;
    run_op(0, v, 1'b1, 1'b0, "rp_b5", res);
    check_vec("rp_b5.only916", res, e);

    v = '0; v[1] = 1'b1; e = '0; e[35] = 1'b1;
    run_op(0, v, 1'b1, 1'b0, "rp_b1", res);
    check_vec("rp_b1.only35", res, e);

    run_op(1, '1, 1'b1, 1'b0, "z4_ones", res);
    check_vec("z4_ones.all", res, '1);

    for (int i = 0; i < 4; i++) run_op(0, rand_state(), bit'($urandom_range(0, 1)), 1'b0, "rnd1", res);
    for (int i = 0; i < 6; i++) run_op(1, rand_state(), bit'($urandom_range(0, 1)), 1'b0, "rnd4", res);

`ifdef PERMUTE_INVERSE_EN
    v = '0; v[10] = 1'b1; e = '0; e[1] = 1'b1;
    run_op(0, v, 1'b0, 1'b1, "ipi_b10", res);
    check_vec("ipi_b10.only1", res, e);
    for (int i = 0; i < 2; i++) begin
      s = rand_state();
      run_op(1, s, 1'b1, 1'b0, "rt_fwd", res);
      run_op(1, res, 1'b1, 1'b1, "rt_inv", res2);
      check_vec("rt.orig", res2, s);
    end
`else
    s = rand_state();
    run_op(0, s, 1'b1, 1'b1, "inv_ignored", res);
    check_vec("inv_ignored.fwd", res, ref_perm(s, 1'b1, 1'b0));
`endif

    // Start held through RUN and DONE, data changed mid-run.
    a = rand_state();
    b = rand_state();
    @(negedge clk);
    data_in = a; mode = 1'b1; inv = 1'b0; start4 = 1'b1;
    @(posedge clk); #1;
    data_in = b;
    wait_done(1, "hs1", res);
    check_vec("hs1.res", res, ref_perm(a, 1'b1, 1'b0));
    check("hs.idle_gap", 64'(busy4), 64'd0);
    @(posedge clk); #1;
    check("hs.restart", 64'(busy4), 64'd1);
    start4 = 1'b0;
    data_in = rand_state();
    wait_done(1, "hs2", res);
    check_vec("hs2.res", res, ref_perm(b, 1'b1, 1'b0));

    // Reset in the middle of a run.
    @(negedge clk);
    data_in = '1; mode = 1'b1; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst_mid.busy", 64'(busy1), 64'd0);
    check("rst_mid.done", 64'(done1), 64'd0);
    check_vec("rst_mid.out", out1, '0);
    @(negedge clk) rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (done1 || busy1) cnt++;
    end
    check("rst_mid.no_done", 64'(cnt), 64'd0);
    run_op(0, rand_state(), 1'b1, 1'b0, "after_rst", res);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
